// File: rtl/elevator_pkg.sv
// ----------------------------------------------------------------------------
// elevator_pkg
// Shared definitions for the elevator call dispatcher slice.
//   DEFAULT_NUM_FLOORS / DEFAULT_FLOOR_W : default geometry of the building
//   floor_t                              : floor index at the default width
//   disp_state_t                         : dispatcher FSM state encoding
// ----------------------------------------------------------------------------
package elevator_pkg;

    localparam int DEFAULT_NUM_FLOORS = 4;
    localparam int DEFAULT_FLOOR_W    = 2;

    typedef logic [DEFAULT_FLOOR_W-1:0] floor_t;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SELECT      = 2'd1,
        OFFER       = 2'd2,
        WAIT_ARRIVE = 2'd3
    } disp_state_t;

endpackage : elevator_pkg

// File: rtl/elevator_call_dispatcher_next_floor_select.sv
// ----------------------------------------------------------------------------
// next_floor_select
// Combinational collective up/down (SCAN) target search.
//   pending    in  NUM_FLOORS  outstanding calls, bit i = floor i
//   cur_floor  in  FLOOR_W     floor the car is standing at
//   dir_up     in  1           current sweep direction, 1 = up
//   sel_floor  out FLOOR_W     chosen target floor
//   sel_dir_up out 1           sweep direction after this choice
// A call at the current floor wins outright. Otherwise the search keeps going
// the current way and only turns around when nothing is left ahead.
// With pending == 0 the outputs echo cur_floor/dir_up and mean nothing.
// ----------------------------------------------------------------------------
module next_floor_select
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS,
    parameter int FLOOR_W    = DEFAULT_FLOOR_W
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  dir_up,
    output logic [FLOOR_W-1:0]    sel_floor,
    output logic                  sel_dir_up
);

    logic               w_here;
    logic               w_found_above;
    logic               w_found_below;
    logic [FLOOR_W-1:0] w_lowest_above;
    logic [FLOOR_W-1:0] w_highest_below;

    always_comb begin
        w_here          = 1'b0;
        w_found_above   = 1'b0;
        w_found_below   = 1'b0;
        w_lowest_above  = '0;
        w_highest_below = '0;

        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (i == int'(cur_floor))) begin
                w_here = 1'b1;
            end
        end

        // Descending scan: the last hit written is the lowest floor above.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(cur_floor))) begin
                w_found_above  = 1'b1;
                w_lowest_above = FLOOR_W'(i);
            end
        end

        // Ascending scan: the last hit written is the highest floor below.
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (i < int'(cur_floor))) begin
                w_found_below   = 1'b1;
                w_highest_below = FLOOR_W'(i);
            end
        end
    end

    always_comb begin
        sel_floor  = cur_floor;
        sel_dir_up = dir_up;
        if (w_here) begin
            sel_floor  = cur_floor;
            sel_dir_up = dir_up;
        end else if (dir_up) begin
            if (w_found_above) begin
                sel_floor  = w_lowest_above;
                sel_dir_up = 1'b1;
            end else if (w_found_below) begin
                sel_floor  = w_highest_below;
                sel_dir_up = 1'b0;
            end
        end else begin
            if (w_found_below) begin
                sel_floor  = w_highest_below;
                sel_dir_up = 1'b0;
            end else if (w_found_above) begin
                sel_floor  = w_lowest_above;
                sel_dir_up = 1'b1;
            end
        end
    end

endmodule : next_floor_select

// File: rtl/elevator_call_dispatcher.sv
// ----------------------------------------------------------------------------
// elevator_call_dispatcher
// Latches floor calls, picks the next target with a SCAN policy and offers it
// to the car controller over a valid/ack handshake.
//   clk           in  1           system clock, rising edge
//   reset         in  1           synchronous, active-high reset
//   btn_press     in  NUM_FLOORS  one-cycle press pulses, bit i = floor i
//   cur_floor     in  FLOOR_W     car position (valid on arrived, IDLE, SELECT)
//   arrived       in  1           car stopped at cur_floor
//   target_valid  out 1           target_floor is being offered
//   target_floor  out FLOOR_W     floor the car must travel to
//   target_ack    in  1           car controller accepts target_floor
//   pending       out NUM_FLOORS  registered outstanding calls
//   dir_up        out 1           current sweep direction, 1 = up
//   busy          out 1           high whenever the FSM is not IDLE
//
// state       | meaning
// ------------+---------------------------------------------------------
// IDLE        | no target in flight; leaves as soon as a call is pending
// SELECT      | one cycle; latches target_floor/dir_up from the search
// OFFER       | target_valid high, target_floor frozen until target_ack
// WAIT_ARRIVE | car travelling; arrived clears its floor and returns IDLE
// ----------------------------------------------------------------------------
module elevator_call_dispatcher
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS,
    parameter int FLOOR_W    = DEFAULT_FLOOR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] btn_press,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  arrived,
    output logic                  target_valid,
    output logic [FLOOR_W-1:0]    target_floor,
    input  logic                  target_ack,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  busy
);

    disp_state_t           r_state;
    logic [NUM_FLOORS-1:0] r_pending;
    logic                  r_target_valid;
    logic [FLOOR_W-1:0]    r_target_floor;
    logic                  r_dir_up;
    logic                  r_busy;

    logic [NUM_FLOORS-1:0] w_clr;
    logic [FLOOR_W-1:0]    w_sel_floor;
    logic                  w_sel_dir_up;

    next_floor_select #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_next_floor_select (
        .pending    (r_pending),
        .cur_floor  (cur_floor),
        .dir_up     (r_dir_up),
        .sel_floor  (w_sel_floor),
        .sel_dir_up (w_sel_dir_up)
    );

    // Arrivals only count while a target is in flight; stray pulses elsewhere
    // must not eat calls.
    always_comb begin
        w_clr = '0;
        if ((r_state == WAIT_ARRIVE) && arrived) begin
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (i == int'(cur_floor)) begin
                    w_clr[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_pending      <= '0;
            r_target_valid <= 1'b0;
            r_target_floor <= '0;
            r_dir_up       <= 1'b1;
            r_busy         <= 1'b0;
        end else begin
            // Clear is applied after the OR so a press on the arrival floor
            // in the same cycle is dropped: the car is already there.
            r_pending <= (r_pending | btn_press) & ~w_clr;

            case (r_state)
                IDLE: begin
                    if (r_pending != '0) begin
                        r_state <= SELECT;
                        r_busy  <= 1'b1;
                    end
                end
                SELECT: begin
                    r_target_floor <= w_sel_floor;
                    r_dir_up       <= w_sel_dir_up;
                    r_target_valid <= 1'b1;
                    r_state        <= OFFER;
                end
                OFFER: begin
                    if (target_ack) begin
                        r_target_valid <= 1'b0;
                        r_state        <= WAIT_ARRIVE;
                    end
                end
                WAIT_ARRIVE: begin
                    if (arrived) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state        <= IDLE;
                    r_target_valid <= 1'b0;
                    r_busy         <= 1'b0;
                end
            endcase
        end
    end

    assign target_valid = r_target_valid;
    assign target_floor = r_target_floor;
    assign pending      = r_pending;
    assign dir_up       = r_dir_up;
    assign busy         = r_busy;

endmodule : elevator_call_dispatcher

// File: tb/tb_elevator_call_dispatcher.sv
module tb_elevator_call_dispatcher;

    logic       clk;
    logic       reset;
    logic [3:0] btn_press;
    logic [1:0] cur_floor;
    logic       arrived;
    logic       target_valid;
    logic [1:0] target_floor;
    logic       target_ack;
    logic [3:0] pending;
    logic       dir_up;
    logic       busy;

    elevator_call_dispatcher #(
        .NUM_FLOORS (4),
        .FLOOR_W    (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_press    (btn_press),
        .cur_floor    (cur_floor),
        .arrived      (arrived),
        .target_valid (target_valid),
        .target_floor (target_floor),
        .target_ack   (target_ack),
        .pending      (pending),
        .dir_up       (dir_up),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int car      = 0;

    // Behavioural model: calls as a bit set, phase as a word.
    bit [3:0] m_pend;
    string    m_phase;
    bit       m_valid;
    int       m_tgt;
    bit       m_dir;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SCAN choice from the call list: floors above/below collected in
    // ascending order, so above[0] is nearest above, below[$] nearest below.
    function automatic void pick(input bit [3:0] p, input int cur, input bit d,
                                 output int f, output bit nd);
        int above[$];
        int below[$];
        f  = cur;
        nd = d;
        for (int i = 0; i < 4; i++) begin
            if (p[i] && i > cur) above.push_back(i);
            if (p[i] && i < cur) below.push_back(i);
        end
        if (p[cur]) begin
            f  = cur;
            nd = d;
        end else if (d) begin
            if (above.size() > 0) begin f = above[0]; nd = 1'b1; end
            else if (below.size() > 0) begin f = below[below.size()-1]; nd = 1'b0; end
        end else begin
            if (below.size() > 0) begin f = below[below.size()-1]; nd = 1'b0; end
            else if (above.size() > 0) begin f = above[0]; nd = 1'b1; end
        end
    endfunction

    task automatic step(input logic [3:0] press, input logic arr, input int cf,
                        input logic ack, input logic rst);
        bit [3:0] clear;
        bit [3:0] nxt;
        int       f;
        bit       nd;
        btn_press  = press;
        arrived    = arr;
        cur_floor  = 2'(cf);
        target_ack = ack;
        reset      = rst;
        @(posedge clk);
        if (rst) begin
            m_pend  = 4'b0;
            m_phase = "idle";
            m_valid = 1'b0;
            m_tgt   = 0;
            m_dir   = 1'b1;
        end else begin
            clear = (m_phase == "wait" && arr) ? 4'(1 << cf) : 4'b0;
            nxt   = (m_pend | press) & ~clear;
            if (m_phase == "idle") begin
                if (m_pend != 4'b0) m_phase = "select";
            end else if (m_phase == "select") begin
                pick(m_pend, cf, m_dir, f, nd);
                m_tgt   = f;
                m_dir   = nd;
                m_valid = 1'b1;
                m_phase = "offer";
            end else if (m_phase == "offer") begin
                if (ack) begin
                    m_valid = 1'b0;
                    m_phase = "wait";
                end
            end else if (m_phase == "wait") begin
                if (arr) m_phase = "idle";
            end
            m_pend = nxt;
        end
        @(negedge clk);
        chk("pending", 32'(pending), 32'(m_pend));
        chk("target_valid", 32'(target_valid), 32'(m_valid));
        chk("target_floor", 32'(target_floor), 32'(m_tgt));
        chk("dir_up", 32'(dir_up), 32'(m_dir));
        chk("busy", 32'(busy), 32'(m_phase != "idle"));
    endtask

    // Wait (bounded) for the offer, check it, accept, then arrive there.
    task automatic serve(input int exp_floor, input bit exp_dir);
        int waited = 0;
        while (!m_valid && waited < 8) begin
            step(4'b0, 1'b0, car, 1'b0, 1'b0);
            waited++;
        end
        chk("serve_offer_seen", 32'(target_valid), 32'd1);
        chk("serve_floor", 32'(target_floor), 32'(exp_floor));
        chk("serve_dir", 32'(dir_up), 32'(exp_dir));
        step(4'b0, 1'b0, car, 1'b1, 1'b0);
        car = m_tgt;
        step(4'b0, 1'b1, car, 1'b0, 1'b0);
    endtask

    initial begin
        btn_press  = 4'b0;
        arrived    = 1'b0;
        cur_floor  = 2'd0;
        target_ack = 1'b0;
        reset      = 1'b1;

        // Reset, then a single call to the top floor.
        step(4'b0, 1'b0, 0, 1'b0, 1'b1);
        step(4'b0, 1'b0, 0, 1'b0, 1'b1);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_valid", 32'(target_valid), 32'd0);
        chk("rst_dir", 32'(dir_up), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        car = 0;
        step(4'b1000, 1'b0, car, 1'b0, 1'b0);
        chk("single_pend_n1", 32'(pending), 32'h8);
        step(4'b0, 1'b0, car, 1'b0, 1'b0);
        chk("single_valid_n2", 32'(target_valid), 32'd0);
        step(4'b0, 1'b0, car, 1'b0, 1'b0);
        chk("single_valid_n3", 32'(target_valid), 32'd1);
        chk("single_floor_n3", 32'(target_floor), 32'd3);
        step(4'b0, 1'b0, car, 1'b1, 1'b0);
        chk("single_ack_drop", 32'(target_valid), 32'd0);
        car = 3;
        step(4'b0, 1'b1, car, 1'b0, 1'b0);
        chk("single_cleared", 32'(pending), 32'd0);
        chk("single_idle", 32'(busy), 32'd0);

        // Sweep order from floor 1 going up with calls at 0, 2, 3.
        car = 1;
        step(4'b1101, 1'b0, car, 1'b0, 1'b0);
        serve(2, 1'b1);
        serve(3, 1'b1);
        serve(0, 1'b0);

        // Handshake hold with an extra press while offering.
        step(4'b0100, 1'b0, car, 1'b0, 1'b0);
        step(4'b0, 1'b0, car, 1'b0, 1'b0);
        step(4'b0, 1'b0, car, 1'b0, 1'b0);
        chk("hold_first_floor", 32'(target_floor), 32'd2);
        for (int i = 0; i < 5; i++) begin
            step((i == 2) ? 4'b0001 : 4'b0000, 1'b0, car, 1'b0, 1'b0);
            chk("hold_valid", 32'(target_valid), 32'd1);
            chk("hold_floor", 32'(target_floor), 32'd2);
        end
        step(4'b0, 1'b0, car, 1'b1, 1'b0);
        chk("hold_ack_drop", 32'(target_valid), 32'd0);

        // Press and clear on the same floor: clear wins.
        car = 2;
        step(4'b0100, 1'b1, car, 1'b0, 1'b0);
        chk("press_clear_pend", 32'(pending), 32'h1);
        chk("press_clear_idle", 32'(busy), 32'd0);
        step(4'b0, 1'b0, car, 1'b0, 1'b0);
        step(4'b0, 1'b0, car, 1'b0, 1'b0);
        chk("flip_down_floor", 32'(target_floor), 32'd0);
        chk("flip_down_dir", 32'(dir_up), 32'd0);

        // Stray arrived while offering.
        step(4'b0, 1'b1, car, 1'b0, 1'b0);
        chk("stray_offer_pend", 32'(pending), 32'h1);
        chk("stray_offer_valid", 32'(target_valid), 32'd1);
        step(4'b0, 1'b0, car, 1'b1, 1'b0);
        car = 0;
        step(4'b0, 1'b1, car, 1'b0, 1'b0);

        // Stray arrived in IDLE together with presses (floor 0 included).
        step(4'b1011, 1'b1, car, 1'b0, 1'b0);
        chk("stray_idle_pend", 32'(pending), 32'hB);
        chk("stray_idle_busy", 32'(busy), 32'd0);
        serve(0, 1'b0);
        step(4'b0, 1'b0, car, 1'b0, 1'b0);
        step(4'b0, 1'b0, car, 1'b0, 1'b0);
        chk("flip_up_floor", 32'(target_floor), 32'd1);
        chk("flip_up_dir", 32'(dir_up), 32'd1);
        chk("pre_reset_pend", 32'(pending), 32'hA);

        // Reset in the middle of an offer.
        step(4'b0, 1'b0, car, 1'b0, 1'b1);
        chk("midrst_valid", 32'(target_valid), 32'd0);
        chk("midrst_pend", 32'(pending), 32'd0);
        chk("midrst_dir", 32'(dir_up), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        car = 0;

        // Random traffic: bench plays the car controller.
        for (int c = 0; c < 800; c++) begin
            logic [3:0] pr;
            logic       a;
            logic       k;
            pr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
            k  = m_valid && ($urandom_range(0, 2) == 0);
            a  = 1'b0;
            if (m_phase == "wait" && $urandom_range(0, 3) == 0) begin
                a   = 1'b1;
                car = m_tgt;
            end else if (m_phase != "wait" && $urandom_range(0, 9) == 0) begin
                a = 1'b1;
            end
            step(pr, a, car, k, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_elevator_call_dispatcher
